// File: rtl/pipe_stage_reg_pkg.sv
// Shared field widths, CTRL layout and per-stage bubble constants for the ThinPad pipeline registers.
// Combinational definitions only; no latency and no flow control of its own.
// Stages pack CTRL with pack_ctrl so the offsets below and the struct layout always agree.
package pipe_stage_reg_pkg;

    localparam int WORD_W    = 16;
    localparam int REG_IDX_W = 4;
    localparam int ALUOP_W   = 4;
    localparam int PERF_W    = 16;

    localparam int DATA_W_DEF = 4 * WORD_W;

    // CTRL bit offsets, LSB first; must match the packed order of ctrl_t
    localparam int CTRL_WB_LSB     = 0;
    localparam int CTRL_MEM_LSB    = 1;
    localparam int CTRL_JORB_LSB   = 3;
    localparam int CTRL_IFJUMP_LSB = 5;
    localparam int CTRL_B_LSB      = 6;
    localparam int CTRL_ALUOP_LSB  = 8;
    localparam int CTRL_RREG2_LSB  = CTRL_ALUOP_LSB + ALUOP_W;
    localparam int CTRL_RREG1_LSB  = CTRL_RREG2_LSB + REG_IDX_W;
    localparam int CTRL_WREG_LSB   = CTRL_RREG1_LSB + REG_IDX_W;
    localparam int CTRL_W_DEF      = CTRL_WREG_LSB + REG_IDX_W;

    typedef struct packed {
        logic [REG_IDX_W-1:0] wreg;
        logic [REG_IDX_W-1:0] rreg1;
        logic [REG_IDX_W-1:0] rreg2;
        logic [ALUOP_W-1:0]   aluop;
        logic [1:0]           controlb;
        logic                 ifjump;
        logic [1:0]           jorb;
        logic [1:0]           controlmem;
        logic                 controlwb;
    } ctrl_t;

    typedef struct packed {
        logic [WORD_W-1:0] rdata1;
        logic [WORD_W-1:0] rdata2;
        logic [WORD_W-1:0] imme;
        logic [WORD_W-1:0] pc;
    } data_t;

    // A bubble must never write a register, touch memory or redirect the PC.
    localparam ctrl_t BUBBLE_ID_EXE  = '0;
    localparam ctrl_t BUBBLE_EXE_MEM = '0;
    localparam ctrl_t BUBBLE_MEM_WB  = '0;

    function automatic logic [CTRL_W_DEF-1:0] pack_ctrl(input ctrl_t c);
        logic [CTRL_W_DEF-1:0] v;
        v = '0;
        v[CTRL_WB_LSB]                              = c.controlwb;
        v[CTRL_MEM_LSB +: 2]                        = c.controlmem;
        v[CTRL_JORB_LSB +: 2]                       = c.jorb;
        v[CTRL_IFJUMP_LSB]                          = c.ifjump;
        v[CTRL_B_LSB +: 2]                          = c.controlb;
        v[CTRL_ALUOP_LSB +: ALUOP_W]                = c.aluop;
        v[CTRL_RREG2_LSB +: REG_IDX_W]              = c.rreg2;
        v[CTRL_RREG1_LSB +: REG_IDX_W]              = c.rreg1;
        v[CTRL_WREG_LSB +: REG_IDX_W]               = c.wreg;
        return v;
    endfunction

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        logic [PERF_W-1:0] r;
        r = v;
        if (en && (v != {PERF_W{1'b1}}))
            r = v + 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Single-entry skid register holding one DATA/CTRL payload with load and clear.
// Latency: one falling edge from load to valid. Backpressure: caller loads only while empty.
// Clear wins over load; payload is kept on clear since valid alone qualifies it.
module pipe_skid_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= in_data;
            ctrl  <= in_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (main + skid, FIFO depth 2) with flush and bubble insertion; PIPE_STAGE_PERF_EN adds stall/flush counters.
// Latency: one falling edge from accept to out_valid when unstalled; full throughput with out_ready high.
// Backpressure: in_ready = !skid_valid, so one extra instruction is absorbed on the first stalled edge.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W      = DATA_W_DEF,
    parameter int                CTRL_W      = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic acc;
    logic take;
    logic main_free;
    logic skid_load;
    logic skid_clear;

    logic              nxt_valid;
    logic [DATA_W-1:0] nxt_data;
    logic [CTRL_W-1:0] nxt_ctrl;

    assign in_ready  = !skid_valid;
    assign acc       = in_valid & in_ready;
    assign take      = out_valid & out_ready;
    assign main_free = !out_valid | take;

    // Skid only ever fills when main is occupied and stalled, so skid_valid implies out_valid.
    assign skid_load  = !flush & !skid_valid & !main_free & acc;
    assign skid_clear = flush | (skid_valid & main_free);

    pipe_skid_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clear   (skid_clear),
        .in_data (in_data),
        .in_ctrl (in_ctrl),
        .valid   (skid_valid),
        .data    (skid_data),
        .ctrl    (skid_ctrl)
    );

    always_comb begin
        nxt_valid = out_valid;
        nxt_data  = out_data;
        nxt_ctrl  = out_ctrl;
        if (flush) begin
            nxt_valid = 1'b0;
            nxt_ctrl  = BUBBLE_CTRL;
        end else if (skid_valid) begin
            if (main_free) begin
                nxt_valid = 1'b1;
                nxt_data  = skid_data;
                nxt_ctrl  = skid_ctrl;
            end
        end else if (main_free) begin
            if (acc) begin
                nxt_valid = 1'b1;
                nxt_data  = in_data;
                nxt_ctrl  = in_ctrl;
            end else begin
                // Data is left stale on a bubble; only CTRL must be neutralised.
                nxt_valid = 1'b0;
                nxt_ctrl  = BUBBLE_CTRL;
            end
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= BUBBLE_CTRL;
        end else begin
            out_valid <= nxt_valid;
            out_data  <= nxt_data;
            out_ctrl  <= nxt_ctrl;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_stall_cnt <= sat_inc(perf_stall_cnt, out_valid & !out_ready);
            perf_flush_cnt <= sat_inc(perf_flush_cnt, flush & (out_valid | skid_valid));
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, async-reset sequence, and random traffic against a queue model.
module tb_pipe_stage_reg;

    localparam logic [23:0] BUB = 24'hF00000;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [23:0] in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [23:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W      (64),
        .CTRL_W      (24),
        .BUBBLE_CTRL (BUB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] d;
        logic [23:0] c;
    } item_t;

    item_t       mq[$];
    logic [63:0] m_last;
    int          m_stall;
    int          m_flush;

    typedef struct {
        logic        iv;
        logic [63:0] d;
        logic [23:0] c;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic        e_ir;
        logic [63:0] e_d;
        logic [23:0] e_c;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [63:0] dn(input int n);
        return {48'h0001_0002_0003, 16'(n)};
    endfunction

    function automatic logic [23:0] cn(input int n);
        return 24'h123400 + 24'(n);
    endfunction

    function automatic vec_t mkv(input logic iv, input int n, input logic ordy, input logic fl,
                                 input logic eov, input logic eir, input int en, input logic ebub);
        vec_t v;
        v.iv   = iv;
        v.d    = dn(n);
        v.c    = cn(n);
        v.ordy = ordy;
        v.fl   = fl;
        v.e_ov = eov;
        v.e_ir = eir;
        v.e_d  = dn(en);
        v.e_c  = ebub ? BUB : cn(en);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: a depth-2 FIFO; the head is what the stage presents.
    task automatic model_reset();
        mq.delete();
        m_last  = '0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic model_edge(input logic iv, input logic [63:0] d, input logic [23:0] c,
                              input logic ordy, input logic fl);
        int  sz;
        bit  acc;
        bit  take;
        item_t it;
        sz   = mq.size();
        acc  = iv && (sz < 2);
        take = (sz > 0) && ordy;
        if (sz > 0 && !ordy && m_stall < 65535) m_stall++;
        if (fl) begin
            if (sz > 0 && m_flush < 65535) m_flush++;
            mq.delete();
        end else begin
            if (take) void'(mq.pop_front());
            if (acc) begin
                it.d = d;
                it.c = c;
                mq.push_back(it);
            end
        end
        if (mq.size() > 0) m_last = mq[0].d;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
        chk({tag, " in_ready"},  64'(in_ready),  64'(mq.size() < 2));
        chk({tag, " out_data"},  out_data, m_last);
        chk({tag, " out_ctrl"},  64'(out_ctrl), 64'((mq.size() > 0) ? mq[0].c : BUB));
`ifdef PIPE_STAGE_PERF_EN
        chk({tag, " perf_stall"}, 64'(perf_stall_cnt), 64'(m_stall));
        chk({tag, " perf_flush"}, 64'(perf_flush_cnt), 64'(m_flush));
`endif
    endtask

    // Inputs change just after a rising edge; the DUT acts on the falling edge; outputs are read 1 after the next rising edge.
    task automatic step(input logic iv, input logic [63:0] d, input logic [23:0] c,
                        input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        model_edge(iv, d, c, ordy, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;

        vecs[0]  = mkv(1, 4,  1, 0, 1, 1, 4,  0);
        vecs[1]  = mkv(1, 5,  1, 0, 1, 1, 5,  0);
        vecs[2]  = mkv(0, 0,  1, 0, 0, 1, 5,  1);
        vecs[3]  = mkv(1, 6,  1, 0, 1, 1, 6,  0);
        vecs[4]  = mkv(0, 0,  1, 0, 0, 1, 6,  1);
        vecs[5]  = mkv(1, 7,  0, 0, 1, 1, 7,  0);
        vecs[6]  = mkv(1, 8,  0, 0, 1, 0, 7,  0);
        vecs[7]  = mkv(1, 9,  0, 0, 1, 0, 7,  0);
        vecs[8]  = mkv(1, 9,  1, 0, 1, 1, 8,  0);
        vecs[9]  = mkv(1, 9,  1, 0, 1, 1, 9,  0);
        vecs[10] = mkv(0, 0,  1, 0, 0, 1, 9,  1);
        vecs[11] = mkv(1, 10, 0, 0, 1, 1, 10, 0);
        vecs[12] = mkv(1, 11, 0, 0, 1, 0, 10, 0);
        vecs[13] = mkv(1, 12, 0, 1, 0, 1, 10, 1);
        vecs[14] = mkv(0, 0,  1, 0, 0, 1, 10, 1);
        vecs[15] = mkv(1, 13, 1, 1, 0, 1, 10, 1);
        vecs[16] = mkv(1, 14, 1, 0, 1, 1, 14, 0);
        vecs[17] = mkv(0, 0,  1, 0, 0, 1, 14, 1);

        do_reset();
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset in_ready",  64'(in_ready),  64'd1);
        chk("reset out_data",  out_data, 64'd0);
        chk("reset out_ctrl",  64'(out_ctrl), 64'(BUB));

        foreach (vecs[i]) begin
            step(vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].ordy, vecs[i].fl);
            chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("vec%0d in_ready", i),  64'(in_ready),  64'(vecs[i].e_ir));
            chk($sformatf("vec%0d out_data", i),  out_data, vecs[i].e_d);
            chk($sformatf("vec%0d out_ctrl", i),  64'(out_ctrl), 64'(vecs[i].e_c));
        end

        // Async reset while main and skid both hold instructions.
        step(1, dn(15), cn(15), 0, 0);
        step(1, dn(16), cn(16), 0, 0);
        chk("stall in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst out_valid", 64'(out_valid), 64'd0);
        chk("arst in_ready",  64'(in_ready),  64'd1);
        chk("arst out_ctrl",  64'(out_ctrl),  64'(BUB));
        chk("arst out_data",  out_data, 64'd0);
        #1;
        rst = 1'b0;
        step(1, dn(17), cn(17), 1, 0);
        chk("post-rst out_valid", 64'(out_valid), 64'd1);
        chk("post-rst out_data",  out_data, dn(17));
        chk("post-rst out_ctrl",  64'(out_ctrl), 64'(cn(17)));

        for (int k = 0; k < 3000; k++) begin
            step(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 24'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
            check_model($sformatf("rnd%0d", k));
        end

`ifdef PIPE_STAGE_PERF_EN
        do_reset();
        step(1, dn(20), cn(20), 0, 0);
        for (int k = 0; k < 5; k++) step(0, '0, '0, 0, 0);
        step(0, '0, '0, 1, 1);
        chk("perf stall 5", 64'(perf_stall_cnt), 64'd5);
        chk("perf flush 1", 64'(perf_flush_cnt), 64'd1);
        step(1, dn(21), cn(21), 0, 0);
        for (int k = 0; k < 65540; k++) step(0, '0, '0, 0, 0);
        chk("perf stall sat", 64'(perf_stall_cnt), 64'hFFFF);
        check_model("perf sat");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
